// File: rtl/psum_collector.sv
// psum_collector: accumulates fp16 partial sums over several passes into a register buffer,
// then drains the final sums over a valid/ready handshake.
module psum_collector #(
   parameter int DEPTH  = 16,
   parameter int PASSES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [15:0] in_psum,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy,
   output logic        done
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [PW-1:0]   pass_q, pass_d;
   logic            done_q, done_d;
   logic            we;
   logic [15:0]     wdata;
   logic [15:0]     buf_q [DEPTH];

   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic [14:0]       ma, mb, mx, my;
      logic              sgx, sgy;
      logic [4:0]        d;
      logic [11:0]       sx, sy, s;
      logic signed [6:0] e;
      ma  = a[14:10] == 5'd0 ? 15'd0 : a[14:0];
      mb  = b[14:10] == 5'd0 ? 15'd0 : b[14:0];
      mx  = ma >= mb ? ma : mb;
      my  = ma >= mb ? mb : ma;
      sgx = ma >= mb ? a[15] : b[15];
      sgy = ma >= mb ? b[15] : a[15];
      d   = mx[14:10] - my[14:10];
      sx  = mx == 15'd0 ? 12'd0 : {2'b01, mx[9:0]};
      sy  = (my == 15'd0 || d >= 5'd11) ? 12'd0 : {2'b01, my[9:0]} >> d;
      s   = sgx == sgy ? sx + sy : sx - sy;
      e   = {2'b00, mx[14:10]};
      if (s[11]) begin
         s = s >> 1;
         e = e + 7'sd1;
      end else begin
         for (int i = 0; i < 11; i++)
            if (!s[10] && s != 12'd0) begin
               s = s << 1;
               e = e - 7'sd1;
            end
      end
      if (a[14:10] == 5'd31 || b[14:10] == 5'd31) return {sgx, 15'h7BFF};
      return s == 12'd0 ? 16'h0000 :
             e < 7'sd1  ? 16'h0000 :
             e > 7'sd30 ? {sgx, 15'h7BFF} : {sgx, e[4:0], s[9:0]};
   endfunction

   assign out_valid = state_q == DRAIN;
   assign out_data  = out_valid ? buf_q[rd_q] : 16'h0000;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign wdata     = pass_q == '0 ? in_psum : fp16_add(buf_q[wr_q], in_psum);

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      we      = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = ACCUM;
            wr_d    = '0;
            rd_d    = '0;
            pass_d  = '0;
         end
         ACCUM: if (in_valid) begin
            we   = 1'b1;
            wr_d = wr_q == AW'(DEPTH-1) ? '0 : wr_q + 1'b1;
            if (wr_q == AW'(DEPTH-1)) begin
               pass_d  = pass_q + 1'b1;
               state_d = pass_q == PW'(PASSES-1) ? DRAIN : ACCUM;
            end
         end
         DRAIN: if (out_ready) begin
            rd_d = rd_q == AW'(DEPTH-1) ? '0 : rd_q + 1'b1;
            if (rd_q == AW'(DEPTH-1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         pass_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   // Pass 0 overwrites every entry, so the buffer needs no reset.
   always_ff @(posedge clk)
      if (we) buf_q[wr_q] <= wdata;
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed fp16 accumulate/drain vectors for psum_collector (DEPTH=4, PASSES=2).
module tb_psum_collector;
   localparam int D = 4;
   localparam int P = 2;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, out_ready;
   logic [15:0] in_psum;
   logic        out_valid, busy, done;
   logic [15:0] out_data;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] e;
   } vec_t;
   vec_t v [16];

   psum_collector #(.DEPTH(D), .PASSES(P)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_psum(in_psum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   task automatic beat(input logic [15:0] d);
      in_valid = 1'b1;
      in_psum  = d;
      chk("busy_accum", 16'(busy), 16'd1);
      chk("valid_accum", 16'(out_valid), 16'd0);
      chk("done_accum", 16'(done), 16'd0);
      @(negedge clk);
   endtask

   task automatic drain(input int base, input bit rnd, input bit b2b);
      int k = 0;
      int cyc = 0;
      chk("drain_latency", 16'(out_valid), 16'd1);
      while (k < D && cyc < 200) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rnd) begin
            in_valid = 1'($urandom_range(0, 1));
            in_psum  = 16'($urandom);
            start    = 1'($urandom_range(0, 1));
         end
         chk("drain_valid", 16'(out_valid), 16'd1);
         chk("drain_data", out_data, v[base+k].e);
         chk("drain_done", 16'(done), 16'd0);
         if (out_ready) k++;
         @(negedge clk);
         cyc++;
      end
      if (k < D) chk("drain_timeout", 16'(k), 16'(D));
      if (!rnd) chk("drain_len", 16'(cyc), 16'(D));
      out_ready = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      chk("done_pulse", 16'(done), 16'd1);
      chk("done_busy", 16'(busy), 16'd0);
      chk("done_valid", 16'(out_valid), 16'd0);
      chk("done_data", out_data, 16'h0000);
      start = b2b;
      @(negedge clk);
      start = 1'b0;
      chk("done_end", 16'(done), 16'd0);
      chk("busy_after", 16'(busy), 16'(b2b));
   endtask

   task automatic tile(input int base, input bit rnd, input bit need_start, input bit b2b);
      if (need_start) begin
         start    = 1'b1;
         in_valid = 1'b1;
         in_psum  = 16'h7777;
         @(negedge clk);
         start = 1'b0;
      end
      for (int p = 0; p < P; p++)
         for (int i = 0; i < D; i++)
            beat(p == 0 ? v[base+i].a : v[base+i].b);
      in_valid = 1'b0;
      drain(base, rnd, b2b);
   endtask

   initial begin
      v[0]  = '{16'h3C00, 16'h3C00, 16'h4000};
      v[1]  = '{16'h3C00, 16'h3800, 16'h3E00};
      v[2]  = '{16'h3C00, 16'hBC00, 16'h0000};
      v[3]  = '{16'h3C00, 16'h4000, 16'h4200};
      v[4]  = '{16'h4000, 16'h3800, 16'h4100};
      v[5]  = '{16'h3C00, 16'h1000, 16'h3C00};
      // Truncated alignment drops the 2^-11 bit of 0xBBFF, leaving 2^-10.
      v[6]  = '{16'h3C00, 16'hBBFF, 16'h1400};
      v[7]  = '{16'h7BFF, 16'h7BFF, 16'h7BFF};
      v[8]  = '{16'hFBFF, 16'hFBFF, 16'hFBFF};
      v[9]  = '{16'h7C00, 16'h3C00, 16'h7BFF};
      v[10] = '{16'hC000, 16'h3C00, 16'hBC00};
      v[11] = '{16'h0200, 16'h3C00, 16'h3C00};
      v[12] = '{16'h0800, 16'h87FF, 16'h0000};
      v[13] = '{16'h7800, 16'h7800, 16'h7BFF};
      v[14] = '{16'h3555, 16'h0000, 16'h3555};
      v[15] = '{16'h3C01, 16'hBC00, 16'h1400};
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_psum = 16'h0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_data", out_data, 16'h0000);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      tile(0, 1'b0, 1'b1, 1'b0);
      tile(4, 1'b0, 1'b1, 1'b1);
      tile(8, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) beat(16'h5A5A);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 16'(out_valid), 16'd0);
      chk("abort_data", out_data, 16'h0000);
      chk("abort_busy", 16'(busy), 16'd0);
      chk("abort_done", 16'(done), 16'd0);
      @(negedge clk);
      chk("abort_done2", 16'(done), 16'd0);
      tile(12, 1'b0, 1'b1, 1'b0);
      tile(0, 1'b1, 1'b1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
